// File: rtl/trng_pkg.sv
// Shared types, defaults and the rotate-priority pick used by the TRNG arbiter.
package trng_pkg;

  localparam int unsigned DEF_WORD_BITS = 16;
  localparam int unsigned DEF_TIMEOUT   = 1024;

  // Widest requester vector the pick function handles (NUM_REQ is 2..8).
  localparam int unsigned MAX_REQ   = 8;
  localparam int unsigned MAX_IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    RELEASE = 2'd2,
    DELIVER = 2'd3
  } trng_state_e;

  // One-hot of the first set request at or after ptr, wrapping modulo n.
  function automatic logic [MAX_REQ-1:0] rr_pick_onehot(
    input logic [MAX_REQ-1:0]   req,
    input logic [MAX_IDX_W-1:0] ptr,
    input int unsigned          n
  );
    logic [MAX_REQ-1:0] pick;
    logic               found;
    int unsigned        idx;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if ((n != 0) && (i < n)) begin
        idx = (32'(ptr) + i) % n;
        if (!found && req[MAX_IDX_W'(idx)]) begin
          pick[MAX_IDX_W'(idx)] = 1'b1;
          found                 = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/trng_arbiter_rr_arbiter.sv
// Combinational round-robin picker: winner one-hot and index from requests and pointer.
module rr_arbiter
  import trng_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] win_c_o,
  output logic [IDX_W-1:0]   win_idx_c_o,
  output logic               any_c_o
);

  logic [MAX_REQ-1:0] req_ext;
  logic [MAX_REQ-1:0] pick;

  // Rotate-priority pick, then encode the winning position.
  always_comb begin
    req_ext     = MAX_REQ'(req_i);
    pick        = rr_pick_onehot(req_ext, MAX_IDX_W'(ptr_i), NUM_REQ);
    win_c_o     = pick[NUM_REQ-1:0];
    any_c_o     = |pick;
    win_idx_c_o = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) begin
        win_idx_c_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/trng_arbiter.sv
// Shares one TRNG bit source between requesters, assembling a full word per grant.
module trng_arbiter
  import trng_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned WORD_BITS      = DEF_WORD_BITS,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [NUM_REQ-1:0]   REQ,
  output logic [NUM_REQ-1:0]   GNT,
  output logic [WORD_BITS-1:0] WORD,
  output logic [NUM_REQ-1:0]   DONE,
  output logic                 ERR,
  output logic                 BUSY,
  output logic                 TRNG_EN,
  input  logic                 TRNG_BIT,
  input  logic                 TRNG_BIT_READY,
  output logic                 TRNG_ACK
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(WORD_BITS + 1);
  localparam int unsigned BIT_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_BITS);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  trng_state_e          state_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [IDX_W-1:0]     gidx_q;
  logic [IDX_W-1:0]     ptr_q;
  logic [WORD_BITS-1:0] word_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [TMO_W-1:0]     tmo_q;
  logic [NUM_REQ-1:0]   done_q;
  logic                 err_q;
  logic                 busy_q;
  logic                 en_q;
  logic                 ack_q;

  logic [NUM_REQ-1:0]   win_c;
  logic [IDX_W-1:0]     win_idx_c;
  logic                 any_c;
  logic [IDX_W-1:0]     next_ptr_c;
  logic [TMO_W-1:0]     tmo_inc_c;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req_i       (REQ),
    .ptr_i       (ptr_q),
    .win_c_o     (win_c),
    .win_idx_c_o (win_idx_c),
    .any_c_o     (any_c)
  );

  // Pointer moves just past the current owner; timeout counter saturates at its limit.
  always_comb begin
    next_ptr_c = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);
    tmo_inc_c  = (tmo_q == TMO_LAST) ? tmo_q : tmo_q + TMO_W'(1);
  end

  // Arbitration, bit collection handshake, timeout abort and delivery.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      done_q <= '0;
      err_q  <= 1'b0;
      ack_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (any_c) begin
            gnt_q   <= win_c;
            gidx_q  <= win_idx_c;
            en_q    <= 1'b1;
            busy_q  <= 1'b1;
            word_q  <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            state_q <= COLLECT;
          end
        end

        COLLECT: begin
          if (TRNG_BIT_READY) begin
            word_q[BIT_W'(cnt_q)] <= TRNG_BIT;
            ack_q   <= 1'b1;
            cnt_q   <= cnt_q + CNT_W'(1);
            tmo_q   <= '0;
            state_q <= RELEASE;
          end else if (tmo_q == TMO_LAST) begin
            err_q   <= 1'b1;
            en_q    <= 1'b0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            tmo_q   <= '0;
            ptr_q   <= next_ptr_c;
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_inc_c;
          end
        end

        // Ready must drop before the next bit is sampled.
        RELEASE: begin
          if (!TRNG_BIT_READY) begin
            if (cnt_q == CNT_FULL) begin
              done_q  <= gnt_q;
              en_q    <= 1'b0;
              tmo_q   <= '0;
              state_q <= DELIVER;
            end else begin
              tmo_q   <= tmo_inc_c;
              state_q <= COLLECT;
            end
          end else if (tmo_q == TMO_LAST) begin
            err_q   <= 1'b1;
            en_q    <= 1'b0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            tmo_q   <= '0;
            ptr_q   <= next_ptr_c;
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_inc_c;
          end
        end

        // DONE is visible here alongside GNT; both clear on the way back to IDLE.
        DELIVER: begin
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          en_q    <= 1'b0;
          ptr_q   <= next_ptr_c;
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign GNT      = gnt_q;
  assign WORD     = word_q;
  assign DONE     = done_q;
  assign ERR      = err_q;
  assign BUSY     = busy_q;
  assign TRNG_EN  = en_q;
  assign TRNG_ACK = ack_q;

endmodule

// File: tb/tb_trng_arbiter.sv
// Self-checking bench for trng_arbiter: TRNG model, requester stimulus and DONE scoreboard.
module tb_trng_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WBITS = 16;
  localparam int unsigned TMO   = 1024;

  logic             CLK;
  logic             RST_N;
  logic [NREQ-1:0]  REQ;
  logic [NREQ-1:0]  GNT;
  logic [WBITS-1:0] WORD;
  logic [NREQ-1:0]  DONE;
  logic             ERR;
  logic             BUSY;
  logic             TRNG_EN;
  logic             TRNG_BIT;
  logic             TRNG_BIT_READY;
  logic             TRNG_ACK;

  trng_arbiter #(
    .NUM_REQ        (NREQ),
    .WORD_BITS      (WBITS),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .REQ            (REQ),
    .GNT            (GNT),
    .WORD           (WORD),
    .DONE           (DONE),
    .ERR            (ERR),
    .BUSY           (BUSY),
    .TRNG_EN        (TRNG_EN),
    .TRNG_BIT       (TRNG_BIT),
    .TRNG_BIT_READY (TRNG_BIT_READY),
    .TRNG_ACK       (TRNG_ACK)
  );

  typedef struct {
    logic [NREQ-1:0]  gnt;
    logic [WBITS-1:0] word;
  } exp_t;

  exp_t            exp_q[$];
  logic [NREQ-1:0] gnt_log[$];

  int n_tests = 0;
  int n_fail  = 0;

  int ack_cnt  = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int ack_viol = 0;
  int oh_viol  = 0;
  int dg_viol  = 0;

  // TRNG model knobs
  int               m_delay = 2;
  int               m_hold  = 0;   // 0: hold ready until ACK, else fixed cycles
  int               m_stop  = 99;  // bits supplied per enable period
  logic [WBITS-1:0] m_base  = 16'hA5C3;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WBITS-1:0] word_for(input logic [NREQ-1:0] g, input logic [WBITS-1:0] base);
    return base ^ ({4{g}} & 16'hEEEE);
  endfunction

  function automatic exp_t mk_exp(input logic [NREQ-1:0] g, input logic [WBITS-1:0] base);
    exp_t e;
    e.gnt  = g;
    e.word = word_for(g, base);
    return e;
  endfunction

  // TRNG bit source, driven on the falling edge
  initial begin
    int mb;
    int mw;
    int mh;
    logic [WBITS-1:0] src;
    mb = 0; mw = 0; mh = 0;
    TRNG_BIT_READY = 1'b0;
    TRNG_BIT       = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RST_N || !TRNG_EN) begin
        TRNG_BIT_READY = 1'b0;
        mb = 0; mw = 0; mh = 0;
      end else if (TRNG_BIT_READY) begin
        mh++;
        if ((m_hold == 0 && TRNG_ACK) || (m_hold != 0 && mh >= m_hold)) begin
          TRNG_BIT_READY = 1'b0;
          mb++;
          mw = 0;
        end
      end else if (mb < m_stop && mb < int'(WBITS)) begin
        if (mw >= m_delay) begin
          src            = word_for(GNT, m_base);
          TRNG_BIT       = src[mb[3:0]];
          TRNG_BIT_READY = 1'b1;
          mh             = 0;
        end else begin
          mw++;
        end
      end
    end
  end

  // Monitor: invariants, event counters and the DONE scoreboard
  initial begin
    logic            prev_ack;
    logic [NREQ-1:0] prev_gnt;
    exp_t            e;
    prev_ack = 1'b0;
    prev_gnt = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (TRNG_ACK) begin
        ack_cnt++;
        if (prev_ack) ack_viol++;
      end
      prev_ack = TRNG_ACK;
      if ($countones(GNT) > 1 || $countones(DONE) > 1) oh_viol++;
      if (DONE != '0 && DONE != GNT) dg_viol++;
      if (GNT != '0 && prev_gnt == '0) gnt_log.push_back(GNT);
      prev_gnt = GNT;
      if (ERR) err_cnt++;
      if (DONE != '0) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check_eq("done_unexpected", 32'(DONE), 32'h0);
        end else begin
          e = exp_q.pop_front();
          check_eq("done_idx", 32'(DONE), 32'(e.gnt));
          check_eq("done_word", 32'(WORD), 32'(e.word));
        end
      end
    end
  end

  // Bounded wait on an event counter (0 done, 1 err, 2 ack)
  task automatic wait_ev(input int which, input int target, input int budget, input string tag);
    int n;
    int cur;
    n   = 0;
    cur = (which == 0) ? done_cnt : (which == 1) ? err_cnt : ack_cnt;
    while (cur < target && n < budget) begin
      @(negedge CLK);
      n++;
      cur = (which == 0) ? done_cnt : (which == 1) ? err_cnt : ack_cnt;
    end
    if (cur < target) check_eq(tag, 32'(cur), 32'(target));
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    REQ   = '0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    int a0;
    int d0;
    int e0;
    RST_N = 1'b0;
    REQ   = '0;
    repeat (2) @(negedge CLK);
    check_eq("rst_ctrl", 32'({GNT, DONE, ERR, BUSY, TRNG_EN, TRNG_ACK}), 32'h0);
    check_eq("rst_word", 32'(WORD), 32'h0);
    RST_N = 1'b1;
    @(negedge CLK);

    // 1: single requester, ACK-paced TRNG
    m_delay = 2; m_hold = 0; m_stop = 99; m_base = 16'hA5C3;
    a0 = ack_cnt; d0 = done_cnt;
    exp_q.push_back(mk_exp(4'b0001, m_base));
    REQ = 4'b0001;
    @(negedge CLK);
    check_eq("t1_gnt", 32'(GNT), 32'h1);
    check_eq("t1_busy_en", 32'({BUSY, TRNG_EN}), 32'h3);
    wait_ev(0, d0 + 1, 400, "t1_done_timeout");
    REQ = '0;
    repeat (2) @(negedge CLK);
    check_eq("t1_acks", 32'(ack_cnt - a0), 32'd16);
    check_eq("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
    check_eq("t1_idle", 32'({GNT, BUSY, TRNG_EN}), 32'h0);
    check_eq("t1_word_held", 32'(WORD), 32'hA5C3);

    // 2: all four requesting, eight words in round-robin order
    do_reset();
    m_delay = 1; m_base = 16'h1357;
    d0 = done_cnt;
    gnt_log.delete();
    for (int k = 0; k < 8; k++) exp_q.push_back(mk_exp(4'(1 << (k % 4)), m_base));
    REQ = 4'b1111;
    wait_ev(0, d0 + 8, 3000, "t2_done_timeout");
    REQ = '0;
    repeat (3) @(negedge CLK);
    check_eq("t2_done_cnt", 32'(done_cnt - d0), 32'd8);
    check_eq("t2_gnt_log_len", 32'(gnt_log.size()), 32'd8);
    for (int k = 0; k < 8 && k < gnt_log.size(); k++)
      check_eq($sformatf("t2_order%0d", k), 32'(gnt_log[k]), 32'(1 << (k % 4)));

    // 3: ready held five cycles per bit
    do_reset();
    m_delay = 1; m_hold = 5; m_base = 16'h3C5A;
    a0 = ack_cnt; d0 = done_cnt;
    exp_q.push_back(mk_exp(4'b0001, m_base));
    REQ = 4'b0001;
    wait_ev(0, d0 + 1, 600, "t3_done_timeout");
    REQ = '0;
    @(negedge CLK);
    check_eq("t3_acks", 32'(ack_cnt - a0), 32'd16);

    // 4: TRNG stalls after eight bits, abort and retry with next requester
    do_reset();
    m_delay = 1; m_hold = 0; m_stop = 8; m_base = 16'h6E21;
    d0 = done_cnt; e0 = err_cnt;
    gnt_log.delete();
    exp_q.push_back(mk_exp(4'b0010, m_base));
    REQ = 4'b0011;
    wait_ev(1, e0 + 1, 3 * TMO, "t4_err_timeout");
    m_stop = 99;
    check_eq("t4_err_cycle", 32'({ERR, TRNG_EN}), 32'h2);
    check_eq("t4_err_gnt_done", 32'({GNT, DONE}), 32'h0);
    check_eq("t4_no_done", 32'(done_cnt - d0), 32'd0);
    wait_ev(0, d0 + 1, 400, "t4_retry_timeout");
    REQ = '0;
    @(negedge CLK);
    check_eq("t4_err_once", 32'(err_cnt - e0), 32'd1);
    check_eq("t4_first_gnt", 32'(gnt_log.size() > 0 ? gnt_log[0] : 4'h0), 32'h1);
    check_eq("t4_retry_gnt", 32'(gnt_log.size() > 1 ? gnt_log[1] : 4'h0), 32'h2);

    // 5: reset asserted at bit 9, then a fresh word for requester 2
    m_base = 16'hC0DE;
    a0 = ack_cnt;
    REQ = 4'b0001;
    wait_ev(2, a0 + 9, 400, "t5_bit9_timeout");
    RST_N = 1'b0;
    #1;
    check_eq("t5_rst_ctrl", 32'({GNT, DONE, ERR, BUSY, TRNG_EN, TRNG_ACK}), 32'h0);
    check_eq("t5_rst_word", 32'(WORD), 32'h0);
    REQ = '0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    d0 = done_cnt; a0 = ack_cnt;
    exp_q.push_back(mk_exp(4'b0100, m_base));
    REQ = 4'b0100;
    @(negedge CLK);
    check_eq("t5_gnt", 32'(GNT), 32'h4);
    wait_ev(0, d0 + 1, 400, "t5_done_timeout");
    REQ = '0;
    @(negedge CLK);
    check_eq("t5_acks", 32'(ack_cnt - a0), 32'd16);

    // 6: requester 0 drops REQ mid-word; pointer must still advance to 1
    m_base = 16'hB00F;
    d0 = done_cnt; a0 = ack_cnt;
    gnt_log.delete();
    exp_q.push_back(mk_exp(4'b0001, m_base));
    exp_q.push_back(mk_exp(4'b0010, m_base));
    REQ = 4'b0001;
    wait_ev(2, a0 + 4, 200, "t6_mid_timeout");
    REQ = '0;
    wait_ev(0, d0 + 1, 400, "t6_done_timeout");
    REQ = 4'b0011;
    wait_ev(0, d0 + 2, 400, "t6_next_timeout");
    REQ = '0;
    repeat (2) @(negedge CLK);
    check_eq("t6_next_gnt", 32'(gnt_log.size() > 1 ? gnt_log[1] : 4'h0), 32'h2);

    check_eq("ack_back_to_back", 32'(ack_viol), 32'd0);
    check_eq("onehot", 32'(oh_viol), 32'd0);
    check_eq("done_vs_gnt", 32'(dg_viol), 32'd0);
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
